// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and
// stream framing constants.
package mips_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_HI = 3'd1,
        ST_HDR_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_LAST   = 3'd4,
        ST_DONE   = 3'd5
    } loader_state_t;

    localparam int WORD_BYTES = 4;
    localparam int HDR_BYTES  = 2;

    // Number of words an ADDR_W-bit word index can address, widened so that
    // it can be compared directly against a 16-bit header count.
    function automatic logic [16:0] capacity(input int addr_w);
        return 17'(1) << addr_w;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
//
// Handshake: a byte moves on a rising edge where in_valid and in_ready are
// both 1. The source holds in_data stable while in_valid=1 and in_ready=0;
// in_valid may drop at any time with no effect on the loader's state.
// imem_we is a one-cycle strobe; imem_waddr/imem_wdata are valid while it is 1.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;

    // Stream source / memory sink side.
    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_waddr, imem_wdata
    );

    // Loader side.
    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_waddr, imem_wdata
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Big-endian 8->32 assembler: each shifted byte enters at the low end, so the
// first byte of a word ends up in bits [31:24].
module byte_packer
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        shift,
    input  logic [7:0]  byte_in,
    output logic [31:0] next_word,
    output logic        word_full
);

    logic [31:0] word_q;
    logic [1:0]  cnt;

    // Word as it will look once byte_in is shifted in.
    assign next_word = {word_q[23:0], byte_in};
    // This shift completes a word; the 2-bit counter wraps to 0 on its own.
    assign word_full = shift && (cnt == 2'(WORD_BYTES - 1));

    // Shift register and byte counter; clr restarts word alignment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            cnt    <= '0;
        end else if (clr) begin
            word_q <= '0;
            cnt    <= '0;
        end else if (shift) begin
            word_q <= next_word;
            cnt    <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Program loader: reads a word-count header and 4*N bytes, writes them into
// instruction memory in order and holds the CPU in reset until the image is
// complete and valid.
module imem_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          cpu_rst_n,
    output logic          busy,
    output logic          done,
    output logic          err,
    output loader_state_t state
);

    localparam logic [16:0] CAPACITY = capacity(ADDR_W);

    logic [7:0]      hdr_hi;
    logic [ADDR_W:0] n_words;
    logic [ADDR_W:0] word_idx;
    logic [ADDR_W:0] idx_next;
    logic [15:0]     n_full;
    logic            accept;
    logic            start_ok;
    logic            shift;
    logic [31:0]     next_word;
    logic            word_full;

    // Ready and busy are pure decodes of the state register.
    assign bus.in_ready = (state == ST_HDR_HI) || (state == ST_HDR_LO) || (state == ST_DATA);
    assign busy         = bus.in_ready || (state == ST_LAST);

    assign accept   = bus.in_valid && bus.in_ready;
    assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign shift    = accept && (state == ST_DATA);
    assign n_full   = {hdr_hi, bus.in_data};
    assign idx_next = word_idx + {{ADDR_W{1'b0}}, 1'b1};

    byte_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (start_ok),
        .shift     (shift),
        .byte_in   (bus.in_data),
        .next_word (next_word),
        .word_full (word_full)
    );

    // Load sequencer with registered write port and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            hdr_hi         <= '0;
            n_words        <= '0;
            word_idx       <= '0;
            bus.imem_we    <= 1'b0;
            bus.imem_waddr <= '0;
            bus.imem_wdata <= '0;
            cpu_rst_n      <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            bus.imem_we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state     <= ST_HDR_HI;
                        done      <= 1'b0;
                        err       <= 1'b0;
                        word_idx  <= '0;
                        cpu_rst_n <= 1'b0;
                    end
                end
                ST_HDR_HI: begin
                    if (accept) begin
                        hdr_hi <= bus.in_data;
                        state  <= ST_HDR_LO;
                    end
                end
                ST_HDR_LO: begin
                    if (accept) begin
                        if ({1'b0, n_full} > CAPACITY) begin
                            // Oversized image: no writes, CPU stays in reset.
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else if (n_full == 16'd0) begin
                            done      <= 1'b1;
                            cpu_rst_n <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            n_words <= n_full[ADDR_W:0];
                            state   <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (word_full) begin
                        bus.imem_we    <= 1'b1;
                        bus.imem_waddr <= word_idx[ADDR_W-1:0];
                        bus.imem_wdata <= next_word;
                        word_idx       <= idx_next;
                        if (idx_next == n_words) begin
                            state <= ST_LAST;
                        end
                    end
                end
                ST_LAST: begin
                    // Final write is on the bus this cycle; release the CPU after it.
                    done      <= 1'b1;
                    cpu_rst_n <= 1'b1;
                    state     <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of whole-image loads plus hand-written
// timing, stall, abort and reset sequences.
module tb_imem_loader;
    import mips_pkg::*;

    localparam int ADDR_W = 8;
    localparam int W      = ADDR_W + 32;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          cpu_rst_n;
    logic          busy;
    logic          done;
    logic          err;
    loader_state_t state;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bus       (bus),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .state     (state)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int            checks      = 0;
    int            failures    = 0;
    int            writes_seen = 0;
    bit            busy_watch  = 1'b0;
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  exp_w;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Every write strobe is matched in order against the expected queue.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            writes_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL extra_write: got addr %0h data %h, expected no write",
                         bus.imem_waddr, bus.imem_wdata);
            end else begin
                exp_w = exp_q.pop_front();
                check("write_addr_data", {bus.imem_waddr, bus.imem_wdata}, exp_w);
            end
        end
        if (busy_watch) check("busy_held", busy, 1'b1);
    end

    // ---------------- driver tasks (enter and leave at a negedge) ----------------
    function automatic logic [31:0] img_word(input logic [31:0] w0, input int k);
        return w0 + 32'(k) * 32'h01010101;
    endfunction

    task automatic push_exp(input int nw, input logic [31:0] w0);
        for (int k = 0; k < nw; k++) exp_q.push_back({ADDR_W'(k), img_word(w0, k)});
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t;
        int idle;
        t = 0;
        if (gaps) begin
            idle = $urandom_range(0, 2);
            repeat (idle) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom_range(0, 255));
                @(negedge clk);
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (t >= 64) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: in_ready stayed %b, expected 1", bus.in_ready);
        end
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int j = 0; j < WORD_BYTES; j++) send_byte(w[31-8*j -: 8], gaps);
    endtask

    task automatic send_image(input logic [15:0] n, input logic [31:0] w0, input int nw, input bit gaps);
        send_byte(n[15:8], gaps);
        send_byte(n[7:0], gaps);
        for (int k = 0; k < nw; k++) send_word(img_word(w0, k), gaps);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (done !== 1'b1 && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (t >= 64) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: done stayed %b, expected 1", done);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] n;
        logic [31:0] w0;
        bit          gaps;
        logic        exp_err;
        logic        exp_cpu;
        int          exp_writes;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{16'd1,   32'h20080005, 1'b0, 1'b0, 1'b1, 1};
        vecs[1] = '{16'd3,   32'h8C010004, 1'b1, 1'b0, 1'b1, 3};
        vecs[2] = '{16'd257, 32'h00000000, 1'b0, 1'b1, 1'b0, 0};
        vecs[3] = '{16'd256, 32'hAC000010, 1'b0, 1'b0, 1'b1, 256};
        vecs[4] = '{16'd0,   32'h00000000, 1'b0, 1'b0, 1'b1, 0};
        vecs[5] = '{16'd2,   32'h3C1F00FF, 1'b1, 1'b0, 1'b1, 2};

        rst_n        = 1'b0;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(negedge clk);

        // Reset values.
        check("rst_state",    state,          ST_IDLE);
        check("rst_in_ready", bus.in_ready,   1'b0);
        check("rst_we",       bus.imem_we,    1'b0);
        check("rst_waddr",    bus.imem_waddr, '0);
        check("rst_wdata",    bus.imem_wdata, '0);
        check("rst_cpu_rst",  cpu_rst_n,      1'b0);
        check("rst_busy",     busy,           1'b0);
        check("rst_done",     done,           1'b0);
        check("rst_err",      err,            1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-word image: exact strobe and release timing.
        push_exp(1, 32'h20080005);
        do_start();
        check("start_ready", bus.in_ready, 1'b1);
        check("start_busy",  busy,         1'b1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_word(32'h20080005, 1'b0);
        bus.in_valid = 1'b0;
        check("t1_we",      bus.imem_we,    1'b1);
        check("t1_waddr",   bus.imem_waddr, 8'h00);
        check("t1_wdata",   bus.imem_wdata, 32'h20080005);
        check("t1_state",   state,          ST_LAST);
        check("t1_done_lo", done,           1'b0);
        check("t1_cpu_lo",  cpu_rst_n,      1'b0);
        @(negedge clk);
        check("t1_done_hi", done,           1'b1);
        check("t1_cpu_hi",  cpu_rst_n,      1'b1);
        check("t1_we_lo",   bus.imem_we,    1'b0);

        // Restart after a successful load drops done/cpu_rst_n next cycle.
        push_exp(1, 32'hDEADBEEF);
        do_start();
        check("re_done", done,      1'b0);
        check("re_cpu",  cpu_rst_n, 1'b0);
        send_image(16'd1, 32'hDEADBEEF, 1, 1'b0);
        wait_done();
        check("re_cpu_hi", cpu_rst_n, 1'b1);

        // Empty image: done the cycle after the second header byte.
        do_start();
        send_image(16'd0, 32'h0, 0, 1'b0);
        check("n0_done", done,      1'b1);
        check("n0_cpu",  cpu_rst_n, 1'b1);
        check("n0_err",  err,       1'b0);

        // Oversized image: done and err the cycle after the header.
        do_start();
        send_image(16'd257, 32'h0, 0, 1'b0);
        check("ovf_done",  done,         1'b1);
        check("ovf_err",   err,          1'b1);
        check("ovf_cpu",   cpu_rst_n,    1'b0);
        check("ovf_ready", bus.in_ready, 1'b0);

        // Table of whole-image loads.
        for (int v = 0; v < 6; v++) begin
            writes_seen = 0;
            push_exp(vecs[v].exp_writes, vecs[v].w0);
            do_start();
            busy_watch = vecs[v].gaps;
            send_image(vecs[v].n, vecs[v].w0, vecs[v].exp_writes, vecs[v].gaps);
            busy_watch = 1'b0;
            wait_done();
            check("vec_done",    done,                   1'b1);
            check("vec_err",     err,                    vecs[v].exp_err);
            check("vec_cpu",     cpu_rst_n,              vecs[v].exp_cpu);
            check("vec_writes",  64'(writes_seen),       64'(vecs[v].exp_writes));
            check("vec_pending", 64'(exp_q.size()),      64'd0);
            check("vec_busy",    busy,                   1'b0);
        end

        // start pulsed mid-word is ignored.
        writes_seen = 0;
        push_exp(2, 32'h11223344);
        do_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        bus.in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mid_start_state", state, ST_DATA);
        check("mid_start_busy",  busy,  1'b1);
        send_byte(8'h44, 1'b0);
        send_word(img_word(32'h11223344, 1), 1'b0);
        bus.in_valid = 1'b0;
        wait_done();
        check("mid_start_writes", 64'(writes_seen), 64'd2);
        check("mid_start_cpu",    cpu_rst_n,        1'b1);

        // Asynchronous reset after 6 data bytes abandons the load.
        push_exp(1, 32'hA5A5C3C3);
        do_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_word(32'hA5A5C3C3, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        bus.in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("arst_state", state,          ST_IDLE);
        check("arst_ready", bus.in_ready,   1'b0);
        check("arst_we",    bus.imem_we,    1'b0);
        check("arst_waddr", bus.imem_waddr, '0);
        check("arst_wdata", bus.imem_wdata, '0);
        check("arst_cpu",   cpu_rst_n,      1'b0);
        check("arst_busy",  busy,           1'b0);
        check("arst_done",  done,           1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_idle_hold", state, ST_IDLE);
        writes_seen = 0;
        push_exp(1, 32'h0BADF00D);
        do_start();
        send_image(16'd1, 32'h0BADF00D, 1, 1'b0);
        wait_done();
        check("arst_reload_writes",  64'(writes_seen),  64'd1);
        check("arst_reload_pending", 64'(exp_q.size()), 64'd0);
        check("arst_reload_cpu",     cpu_rst_n,         1'b1);

        // ---------------- final report ----------------
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
